// File: rtl/occupancy_setpoint_ramp_pkg.sv
// occupancy_pkg: shared types and helpers for the occupancy setpoint ramp.
//   state_t   - setpoint FSM states (OFF / IDLE / RAMP)
//   bcd_t     - one BCD digit
//   band_edge - lowest person count of band k (k >= 1)
package occupancy_pkg;

    typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_RAMP} state_t;

    typedef logic [3:0] bcd_t;

    // "edge" is a reserved word, hence band_edge.
    function automatic int band_edge(input int k, input int first_edge, input int band_step);
        return first_edge + (k - 1) * band_step;
    endfunction

endpackage

// File: rtl/occupancy_setpoint_ramp_if.sv
// occupancy_setpoint_ramp_if: panel/occupancy inputs and setpoint outputs.
//   selector     - panel mode, sampling only at the block's select code
//   person_tens  - BCD tens of occupancy
//   person_ones  - BCD ones of occupancy
//   temp_tens    - BCD tens of current setpoint
//   temp_ones    - BCD ones of current setpoint
//   settled      - setpoint equals target (not ramping)
//   bcd_error    - sticky invalid-digit flag
// master drives the occupancy side, slave is the setpoint block.
interface occupancy_setpoint_ramp_if;
    import occupancy_pkg::*;

    logic [7:0] selector;
    bcd_t       person_tens;
    bcd_t       person_ones;
    bcd_t       temp_tens;
    bcd_t       temp_ones;
    logic       settled;
    logic       bcd_error;

    modport master (
        output selector, person_tens, person_ones,
        input  temp_tens, temp_ones, settled, bcd_error
    );

    modport slave (
        input  selector, person_tens, person_ones,
        output temp_tens, temp_ones, settled, bcd_error
    );
endinterface

// File: rtl/occupancy_setpoint_ramp_bin2bcd_99.sv
// bin2bcd_99: combinational 7-bit binary to two BCD digits, saturating at 99.
//   bin  - binary input 0..127
//   tens - BCD tens digit
//   ones - BCD ones digit
module bin2bcd_99
    import occupancy_pkg::*;
(
    input  logic [6:0] bin,
    output bcd_t       tens,
    output bcd_t       ones
);
    logic [6:0] sat;

    always_comb begin
        sat  = (bin > 7'd99) ? 7'd99 : bin;
        tens = 4'(sat / 7'd10);
        ones = 4'(sat % 7'd10);
    end
endmodule

// File: rtl/occupancy_setpoint_ramp.sv
// occupancy_setpoint_ramp: samples a BCD person count, classifies it into
// occupancy bands with hysteresis and drives a BCD temperature setpoint
// toward the band target.
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - occupancy_setpoint_ramp_if.slave (selector, person digits in;
//         temp digits, settled, bcd_error out)
// Pipeline: count -> band/target -> cur (FSM) -> BCD output register.
// Build option OCCUPANCY_SETPOINT_RAMP_EN: when defined, the setpoint walks
// one degree every RAMP_DIV cycles; otherwise it follows the target directly.
module occupancy_setpoint_ramp
    import occupancy_pkg::*;
#(
    parameter int SELECT_CODE = 3,
    parameter int NUM_BANDS   = 4,
    parameter int FIRST_EDGE  = 15,
    parameter int BAND_STEP   = 10,
    parameter int HYST        = 2,
    parameter int BASE_TEMP   = 26,
    parameter int TEMP_STEP   = 2,
    parameter int RAMP_DIV    = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    occupancy_setpoint_ramp_if.slave  bus
);

    if (NUM_BANDS < 1 || NUM_BANDS > 8 || RAMP_DIV < 1) begin : g_bad_cfg
        $error("occupancy_setpoint_ramp: unsupported parameter set");
    end

    // ---------------- stage S: sample ----------------
    logic [6:0] count;
    logic       bcd_error;
    logic       digits_ok;

    assign digits_ok = (bus.person_tens <= 4'd9) && (bus.person_ones <= 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            bcd_error <= 1'b0;
        end else if (bus.selector == 8'(SELECT_CODE)) begin
            if (digits_ok)
                count <= 7'(bus.person_tens) * 7'd10 + 7'(bus.person_ones);
            else
                bcd_error <= 1'b1;
        end
    end

    // ---------------- stage B: band with hysteresis ----------------
    function automatic logic [2:0] raw_band(input int c);
        int b;
        if (c < FIRST_EDGE) b = 0;
        else                b = 1 + (c - FIRST_EDGE) / BAND_STEP;
        if (b > NUM_BANDS - 1) b = NUM_BANDS - 1;
        return 3'(b);
    endfunction

    logic [2:0] band, band_nxt, raw;
    logic [6:0] target;

    always_comb begin
        raw      = raw_band(int'(count));
        band_nxt = band;
        if (count == '0)
            band_nxt = '0;
        // target==0 means OFF: leaving OFF takes the raw band, no hysteresis
        else if (target == '0 || raw > band)
            band_nxt = raw;
        // drop only once clearly below the current band's edge; landing on
        // raw(count+HYST) keeps the new band from sitting right on its edge
        else if (raw < band &&
                 int'(count) < band_edge(int'(band), FIRST_EDGE, BAND_STEP) - HYST)
            band_nxt = raw_band(int'(count) + HYST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            band   <= '0;
            target <= '0;
        end else begin
            band   <= band_nxt;
            target <= (count == '0) ? 7'd0
                                    : 7'(BASE_TEMP - int'(band_nxt) * TEMP_STEP);
        end
    end

    // ---------------- setpoint FSM ----------------
    state_t     state;
    logic [6:0] cur;
    logic       settled;

`ifdef OCCUPANCY_SETPOINT_RAMP_EN
    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            cur      <= '0;
            tick_cnt <= '0;
            settled  <= 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    if (target != '0) begin
                        cur   <= target;
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (target == '0) begin
                        cur   <= '0;
                        state <= ST_OFF;
                    end else if (target != cur) begin
                        tick_cnt <= '0;
                        state    <= ST_RAMP;
                        settled  <= 1'b0;
                    end
                end
                ST_RAMP: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (target == '0) begin
                        cur     <= '0;
                        state   <= ST_OFF;
                        settled <= 1'b1;
                    end else if (cur == target) begin
                        state   <= ST_IDLE;
                        settled <= 1'b1;
                    end else if (tick) begin
                        // direction taken per tick so a retarget redirects the walk
                        cur <= (target > cur) ? cur + 7'd1 : cur - 7'd1;
                    end
                end
                default: begin
                    cur     <= '0;
                    state   <= ST_OFF;
                    settled <= 1'b1;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            cur   <= '0;
        end else begin
            cur   <= target;
            state <= (target == '0) ? ST_OFF : ST_IDLE;
        end
    end

    assign settled = 1'b1;
`endif

    // ---------------- output stage ----------------
    bcd_t tens_c, ones_c, temp_tens, temp_ones;

    bin2bcd_99 u_bcd (
        .bin  (cur),
        .tens (tens_c),
        .ones (ones_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_tens <= '0;
            temp_ones <= '0;
        end else begin
            temp_tens <= tens_c;
            temp_ones <= ones_c;
        end
    end

    assign bus.temp_tens = temp_tens;
    assign bus.temp_ones = temp_ones;
    assign bus.settled   = settled;
    assign bus.bcd_error = bcd_error;

endmodule

// File: tb/tb_occupancy_setpoint_ramp.sv
// Directed bench for occupancy_setpoint_ramp with RAMP_DIV=4. Expected
// setpoints are hand-derived from the band table:
//   band0 1..14 -> 26, band1 15..24 -> 24, band2 25..34 -> 22, band3 35+ -> 20.
// Expectations follow OCCUPANCY_SETPOINT_RAMP_EN when it is defined.
module tb_occupancy_setpoint_ramp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    occupancy_setpoint_ramp_if bus ();

    occupancy_setpoint_ramp #(.RAMP_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] sel, input logic [3:0] t, input logic [3:0] o);
        bus.selector    = sel;
        bus.person_tens = t;
        bus.person_ones = o;
    endtask

    task automatic chk(input string tag, input int exp_temp, input logic exp_settled,
                       input logic exp_err);
        logic [3:0] et, eo;
        et = 4'(exp_temp / 10);
        eo = 4'(exp_temp % 10);
        checks++;
        assert (bus.temp_tens === et && bus.temp_ones === eo &&
                bus.settled === exp_settled && bus.bcd_error === exp_err)
        else begin
            errors++;
            $error("FAIL %s: observed temp=%h%h settled=%b err=%b, expected temp=%h%h settled=%b err=%b",
                   tag, bus.temp_tens, bus.temp_ones, bus.settled, bus.bcd_error,
                   et, eo, exp_settled, exp_err);
        end
    endtask

    initial begin
        // reset with 0 persons presented
        drive(8'd3, 4'd0, 4'd0);
        rst = 1'b1;
        step(2);
        chk("reset", 0, 1'b1, 1'b0);
        rst = 1'b0;
        step(4);
        chk("zero_off_a", 0, 1'b1, 1'b0);
        step(4);
        chk("zero_off_b", 0, 1'b1, 1'b0);

        // 10 persons from OFF: direct jump to 26 at N+4
        drive(8'd3, 4'd1, 4'd0);
        step(3);
        chk("off_exit_n3", 0, 1'b1, 1'b0);
        step(1);
        chk("off_exit_n4", 26, 1'b1, 1'b0);

        // other selector value: count must hold
        drive(8'd0, 4'd4, 4'd0);
        step(6);
        chk("deselect_hold", 26, 1'b1, 1'b0);

        // 30 persons -> band 2, target 22
        drive(8'd3, 4'd3, 4'd0);
`ifdef OCCUPANCY_SETPOINT_RAMP_EN
        step(4);  chk("ramp_entry", 26, 1'b0, 1'b0);
        step(4);  chk("ramp_25",    25, 1'b0, 1'b0);
        step(4);  chk("ramp_24",    24, 1'b0, 1'b0);
        step(4);  chk("ramp_23",    23, 1'b0, 1'b0);
        step(4);  chk("ramp_22",    22, 1'b1, 1'b0);
`else
        step(4);  chk("jump_22",    22, 1'b1, 1'b0);
`endif

        // 24 persons: not below 25-2, band 2 holds
        drive(8'd3, 4'd2, 4'd4);
        step(8);
        chk("hyst_hold", 22, 1'b1, 1'b0);

        // 22 persons: below 23, drop to band raw(24)=1 -> 24
        drive(8'd3, 4'd2, 4'd2);
`ifdef OCCUPANCY_SETPOINT_RAMP_EN
        step(4);  chk("hyst_up_entry", 22, 1'b0, 1'b0);
        step(4);  chk("hyst_up_23",    23, 1'b0, 1'b0);
        step(4);  chk("hyst_up_24",    24, 1'b1, 1'b0);
`else
        step(4);  chk("hyst_drop_24",  24, 1'b1, 1'b0);
`endif

        // 99 persons saturate to top band (20); then 0 persons mid-ramp
        drive(8'd3, 4'd9, 4'd9);
`ifdef OCCUPANCY_SETPOINT_RAMP_EN
        step(8);  chk("sat_ramp_23", 23, 1'b0, 1'b0);
`else
        step(4);  chk("sat_20",      20, 1'b1, 1'b0);
`endif
        drive(8'd3, 4'd0, 4'd0);
        step(4);
        chk("to_off", 0, 1'b1, 1'b0);

        // invalid ones digit: sticky error, outputs unchanged
        drive(8'd3, 4'd1, 4'hA);
        step(1);
        chk("bcd_err_set", 0, 1'b1, 1'b1);
        step(4);
        chk("bcd_err_hold", 0, 1'b1, 1'b1);
        drive(8'd3, 4'd1, 4'd0);
        step(4);
        chk("bcd_err_sticky", 26, 1'b1, 1'b1);

        // reset during a ramp
        drive(8'd3, 4'd9, 4'd9);
`ifdef OCCUPANCY_SETPOINT_RAMP_EN
        step(8);  chk("pre_reset_25", 25, 1'b0, 1'b1);
`else
        step(8);  chk("pre_reset_20", 20, 1'b1, 1'b1);
`endif
        rst = 1'b1;
        drive(8'd3, 4'd0, 4'd0);
        step(1);
        chk("reset_mid", 0, 1'b1, 1'b0);
        rst = 1'b0;
        step(4);
        chk("after_reset", 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
